// File: rtl/async_capture_pkg.sv
// Shared types and helpers for the asynchronous bus capture block.
// WAIT_LOW exists only when ASYNC_CAPTURE_TIMEOUT_EN is defined.
package async_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    PRESENT,
    ACK
`ifdef ASYNC_CAPTURE_TIMEOUT_EN
    , WAIT_LOW
`endif
  } state_t;

  // One counter serves both the settle window and the strobe-release timeout.
  function automatic int cnt_width(input int settle, input int timeout);
    int m;
    m = (settle > timeout) ? settle : timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/async_bus_capture_sync.sv
// Multi-stage flop synchronizer; ena freezes every stage, reset clears them.
module async_bus_capture_sync #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else if (ena) begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/async_bus_capture.sv
// 4-phase req/ack receiver: synchronize, settle, present on valid/ready, ack.
// Optional strobe-release timeout enabled by ASYNC_CAPTURE_TIMEOUT_EN.
module async_bus_capture
  import async_capture_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int STAGES         = 2,
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             strobe_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             err_out,
  input  logic             err_clr
);

  localparam int CW = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
`ifdef ASYNC_CAPTURE_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
`endif

  logic [WIDTH:0]   sync_q;
  logic             strb_s;
  logic [WIDTH-1:0] data_s;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             capture, err_set;
  logic             valid_nxt, ack_nxt, err_nxt;
  logic [WIDTH-1:0] data_nxt;

  async_bus_capture_sync #(
    .WIDTH  (WIDTH + 1),
    .STAGES (STAGES)
  ) u_sync (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .d    ({strobe_in, data_in}),
    .q    (sync_q)
  );

  assign strb_s = sync_q[WIDTH];
  assign data_s = sync_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      cnt       <= '0;
      valid_out <= 1'b0;
      ack_out   <= 1'b0;
      data_out  <= '0;
      err_out   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      valid_out <= valid_nxt;
      ack_out   <= ack_nxt;
      data_out  <= data_nxt;
      err_out   <= err_nxt;
    end
  end

  // With ena low every next value equals the current one, so the whole block holds.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    err_set   = 1'b0;
    if (ena) begin
      case (state)
        IDLE: begin
          if (strb_s) begin
            state_nxt = SETTLE;
            cnt_nxt   = SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (!strb_s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            err_set   = 1'b1;
          end else if (cnt == '0) begin
            state_nxt = PRESENT;
            capture   = 1'b1;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        PRESENT: begin
          if (ready_in) begin
            state_nxt = ACK;
`ifdef ASYNC_CAPTURE_TIMEOUT_EN
            cnt_nxt   = TIMEOUT_LOAD;
`endif
          end
        end
        ACK: begin
          if (!strb_s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
`ifdef ASYNC_CAPTURE_TIMEOUT_EN
          end else if (cnt == '0) begin
            state_nxt = WAIT_LOW;
            err_set   = 1'b1;
          end else begin
            cnt_nxt = cnt - CW'(1);
`endif
          end
        end
`ifdef ASYNC_CAPTURE_TIMEOUT_EN
        WAIT_LOW: begin
          if (!strb_s) state_nxt = IDLE;
        end
`endif
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, keeping ready_in off any output path.
  always_comb begin
    valid_nxt = (state_nxt == PRESENT);
    ack_nxt   = (state_nxt == ACK);
    data_nxt  = capture ? data_s : data_out;
    err_nxt   = err_out;
    if (err_set) err_nxt = 1'b1;
    else if (ena && err_clr) err_nxt = 1'b0;
  end

endmodule
